// File: rtl/load_store_unit.sv
// load_store_unit: rv32i memory stage driving a word-addressed req/ack data port.
// Holds the datapath with stall while an access is in flight and flags bad or timed-out accesses.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  f3,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        stall,
  output logic        fault,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memBe,
  input  logic [31:0] memRdata,
  input  logic        memAck
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d, fault_q, fault_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, rd_q, rd_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic        req, legal, misaligned, bad, good;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val, store_data;
  logic [3:0]  store_be;
  assign req        = memRead | memWrite;
  assign legal      = memRead ? (f3 != 3'b011 && f3[2:1] != 2'b11) : (!f3[2] && f3[1:0] != 2'b11);
  assign misaligned = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign bad        = (memRead & memWrite) | ~legal | misaligned;
  assign good       = req & ~bad;
  assign stall      = reset & (state_q == WAIT || (state_q == IDLE && good));
  // Load lane uses the offset and size latched at request time, not the live inputs.
  assign lane_b   = off_q[1] ? (off_q[0] ? memRdata[31:24] : memRdata[23:16])
                             : (off_q[0] ? memRdata[15:8]  : memRdata[7:0]);
  assign lane_h   = off_q[1] ? memRdata[31:16] : memRdata[15:0];
  assign load_val = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane_b[7]}}, lane_b}
                  : f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane_h[15]}}, lane_h}
                  : memRdata;
  assign store_data = f3[1:0] == 2'b00 ? {4{wd[7:0]}} : f3[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
  assign store_be   = !memWrite ? 4'b0000
                    : f3[1:0] == 2'b00 ? 4'b0001 << addr[1:0]
                    : f3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011)
                    : 4'b1111;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    off_d       = off_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    fault_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && bad) begin
          fault_d = 1'b1;
          rd_d    = '0;
        end else if (good) begin
          state_d     = WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = memWrite;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_wdata_d = store_data;
          mem_be_d    = store_be;
          off_d       = addr[1:0];
          f3_d        = f3;
          cnt_d       = '0;
        end
      end
      WAIT: begin
        if (memAck) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          rd_d      = mem_we_q ? rd_q : load_val;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          fault_d   = 1'b1;
          rd_d      = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      rd_q        <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      rd_q        <= rd_d;
      fault_q     <= fault_d;
    end
  end
  assign rd       = rd_q;
  assign fault    = fault_q;
  assign memReq   = mem_req_q;
  assign memWe    = mem_we_q;
  assign memAddr  = mem_addr_q;
  assign memWdata = mem_wdata_q;
  assign memBe    = mem_be_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized accesses checked against a byte-arithmetic model.
module tb_load_store_unit;
  localparam int TIMEOUT = 16;
  logic        clk = 1'b0, reset = 1'b0, memRead = 1'b0, memWrite = 1'b0, memAck = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0, wd = '0, memRdata = '0;
  logic [31:0] rd, memAddr, memWdata;
  logic        stall, fault, memReq, memWe;
  logic [3:0]  memBe;
  int          vectors = 0, miscompares = 0;
  logic [31:0] exp_rd = '0;
  always #5 clk = ~clk;
  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite), .f3(f3),
    .addr(addr), .wd(wd), .rd(rd), .stall(stall), .fault(fault), .memReq(memReq),
    .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe),
    .memRdata(memRdata), .memAck(memAck)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // delay = WAIT cycles before memAck; negative or >= TIMEOUT means the ack never comes.
  task automatic access(input logic r, input logic w, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rdat, input int delay);
    int nb;
    logic good, acked;
    logic [31:0] mask, val, be, wdat, a_word;
    nb   = 1 << fn[1:0];
    good = (r ^ w) && (r ? (fn inside {0, 1, 2, 4, 5}) : (fn inside {0, 1, 2})) && (a % nb == 0);
    mask = nb >= 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 1;
    be   = w ? ((32'd1 << nb) - 1) << (a % 4) : 32'd0;
    wdat = nb == 1 ? d[7:0] * 32'h0101_0101 : nb == 2 ? d[15:0] * 32'h0001_0001 : d;
    val  = (rdat >> (8 * (a % 4))) & mask;
    if (!fn[2] && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
    a_word = a - (a % 4);
    memRead = r; memWrite = w; f3 = fn; addr = a; wd = d;
    #1;
    chk("stall_on_request", stall, good);
    tick();
    memRead = 1'b0; memWrite = 1'b0; f3 = 3'($urandom); addr = $urandom; wd = $urandom;
    if (!good) begin
      exp_rd = '0;
      chk("bad_fault", fault, 1);
      chk("bad_no_req", memReq, 0);
      chk("bad_rd", rd, exp_rd);
      chk("bad_stall", stall, 0);
      tick();
      chk("bad_fault_pulse", fault, 0);
      return;
    end
    chk("req_start", memReq, 1);
    chk("req_we", memWe, w);
    chk("req_addr", memAddr, a_word);
    chk("req_be", memBe, be);
    if (w) chk("req_wdata", memWdata, wdat);
    chk("wait_stall", stall, 1);
    chk("wait_fault", fault, 0);
    acked = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (i == delay) begin
        memAck = 1'b1; memRdata = rdat; acked = 1'b1;
      end else memRdata = $urandom;
      tick();
      memAck = 1'b0;
      if (acked || i == TIMEOUT - 1) break;
      chk("req_held", memReq, 1);
      chk("addr_held", memAddr, a_word);
      chk("be_held", memBe, be);
      chk("stall_held", stall, 1);
    end
    if (acked) begin
      if (r) exp_rd = val;
      chk("done_req_drop", memReq, 0);
      chk("done_stall", stall, 0);
      chk("done_fault", fault, 0);
      chk("done_rd", rd, exp_rd);
      memRead = 1'b1; f3 = 3'b010; addr = 32'h3;
      tick();
      memRead = 1'b0;
      chk("done_req_ignored", fault, 0);
      chk("done_no_new_req", memReq, 0);
    end else begin
      exp_rd = '0;
      chk("timeout_req", memReq, 0);
      chk("timeout_fault", fault, 1);
      chk("timeout_rd", rd, exp_rd);
      chk("timeout_stall", stall, 0);
      tick();
      chk("timeout_fault_pulse", fault, 0);
    end
  endtask
  initial begin
    tick();
    chk("rst_req", memReq, 0);
    chk("rst_stall", stall, 0);
    chk("rst_addr", memAddr, 0);
    chk("rst_wdata", memWdata, 0);
    reset = 1'b1;
    tick();
    chk("post_rst_req", memReq, 0);
    chk("post_rst_we", memWe, 0);
    chk("post_rst_be", memBe, 0);
    chk("post_rst_rd", rd, 0);
    chk("post_rst_fault", fault, 0);
    chk("post_rst_stall", stall, 0);
    access(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
    access(1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF_7F01, 0);
    chk("lb_rd", rd, 32'hFFFF_FF80);
    access(1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF_7F01, 1);
    chk("lbu_rd", rd, 32'h0000_0080);
    access(1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 0);
    chk("lh_rd", rd, 32'hFFFF_8001);
    access(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
    access(0, 1, 3'b000, 32'h45, 32'h1234_5678, 32'h0, 3);
    access(1, 0, 3'b000, 32'h10, 32'h0, 32'h0, -1);
    access(1, 1, 3'b010, 32'h20, 32'h5, 32'h0, 0);
    access(1, 0, 3'b011, 32'h20, 32'h0, 32'h0, 0);
    access(1, 0, 3'b010, 32'h24, 32'h0, 32'h1357_9BDF, TIMEOUT - 1);
    memAck = 1'b1; memRdata = 32'hFFFF_FFFF;
    tick();
    memAck = 1'b0;
    chk("stray_ack_req", memReq, 0);
    chk("stray_ack_rd", rd, exp_rd);
    memWrite = 1'b1; f3 = 3'b010; addr = 32'h40; wd = 32'h1;
    tick();
    memWrite = 1'b0;
    chk("pre_reset_req", memReq, 1);
    #2 reset = 1'b0;
    #1;
    exp_rd = '0;
    chk("async_rst_req", memReq, 0);
    chk("async_rst_stall", stall, 0);
    chk("async_rst_rd", rd, exp_rd);
    #1 reset = 1'b1;
    tick();
    chk("after_rst_req", memReq, 0);
    chk("after_rst_stall", stall, 0);
    for (int n = 0; n < 300; n++) begin
      int kind, dly;
      kind = $urandom_range(0, 9);
      dly  = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, 4);
      access(kind == 0 || kind >= 5, kind <= 4, 3'($urandom_range(0, 7)),
             $urandom, $urandom, $urandom, dly);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sequential memory-access stage directly downstream of the rv32i datapath's ALU. It consumes the effective address (ALU result), store data (rs2 value) and funct3. It drives a word-addressed external data-memory port with byte enables over a req/ack handshake, and returns sign- or zero-extended load data to the result mux. It holds the datapath with a stall while an access is in flight and flags misaligned, illegal or timed-out accesses.

Parameters:
TIMEOUT, 16, maximum cycles spent in WAIT before the access is abandoned with fault (must be >= 1).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
memRead  input  1  load request from control unit.
memWrite  input  1  store request from control unit.
f3  input  3  funct3 of the current instruction.
addr  input  32  effective byte address (ALU result).
wd  input  32  store data (rs2).
rd  output  32  extended load result to the result mux.
stall  output  1  hold PC and register write while high.
fault  output  1  one-cycle pulse on misaligned, illegal f3, read+write conflict, or timeout.
memReq  output  1  external request, held until memAck.
memWe  output  1  1 = write, 0 = read; valid while memReq.
memAddr  output  32  {addr[31:2],2'b00}, registered.
memWdata  output  32  lane-replicated store data, registered.
memBe  output  4  byte enables, registered; 4'b0000 for reads.
memRdata  input  32  read data, valid with memAck.
memAck  input  1  one-cycle completion strobe.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; memReq, memWe, stall, fault = 0; memAddr, memWdata, rd = 0; memBe = 0; timeout counter = 0.
- States: IDLE, WAIT, DONE.
- Access sizes:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other f3 with a request is illegal.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
- IDLE with request:
  - Bad request (illegal f3, misaligned, or memRead&memWrite): no memReq; fault=1 for one cycle; stall=0; rd=0; stay in IDLE.
  - Good request: stall=1 combinationally in the same cycle. On the clock edge, register memAddr, memWe, memBe, memWdata, addr[1:0] and f3; set memReq=1; clear the counter; go to WAIT.
- Store lanes:
  - sb: memWdata={4{wd[7:0]}}, memBe=4'b0001<<addr[1:0].
  - sh: memWdata={2{wd[15:0]}}, memBe = addr[1] ? 4'b1100 : 4'b0011.
  - sw: memWdata=wd, memBe=4'b1111.
- WAIT: stall=1; memReq and all mem outputs held stable.
  - memAck=1: memReq drops at the next edge; for a load, rd is registered from memRdata (lane selected by the latched addr[1:0], extended per the latched f3); go to DONE.
  - No ack: counter increments. When the counter reaches TIMEOUT-1 without ack: memReq drops, fault pulses one cycle, rd=0, go to IDLE.
- DONE: stall=0; rd valid (holds the value for stores and is not updated); fault=0. The datapath advances at this edge. Requests seen in DONE belong to the completed instruction and are ignored. Next state is IDLE.
- Minimum access latency: request cycle + 1 WAIT cycle (ack in first WAIT cycle) + DONE = 3 cycles.
- rd holds its last value except on load completion, fault, or reset.
- memAck outside WAIT is ignored.
- Reset asserted mid-WAIT drops memReq immediately (asynchronous); the external memory must tolerate an abandoned request.

Test Plan:
1. Reset low then high, no requests -> all outputs 0, state IDLE, stall=0.
2. sw addr=0x100, wd=0xDEADBEEF, ack on first WAIT cycle -> memReq for 1 cycle, memAddr=0x100, memBe=1111, memWdata=0xDEADBEEF, stall high 2 cycles, fault=0.
3. Loads at addr=0x203, memRdata=0x80FF7F01:
   - lb -> rd=0xFFFFFF80.
   - lbu -> rd=0x00000080.
4. lh at addr=0x102 with memRdata=0x8001xxxx -> rd=0xFFFF8001, memBe=0000. lw at addr=0x102 -> fault pulse, no memReq, stall=0.
5. sb addr=0x45 wd=0x12345678, ack delayed 3 cycles -> memBe=0010, memWdata=0x78787878, memReq held 4 cycles stable. Then memAck withheld, TIMEOUT=16 -> fault after 16 WAIT cycles, memReq drops.
6. memRead&memWrite together, or f3=011 on a load -> fault pulse, no memReq. Reset pulsed during WAIT -> memReq and stall fall asynchronously, state IDLE.
